// File: rtl/mult_div_pkg.sv
// Shared constants and FSM state encoding for the iterative signed multiply/divide unit.
package mult_div_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ITER   = 32;
  localparam int unsigned CNT_W  = $clog2(ITER);

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitudes and result sign fix-up.
module sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] value,
  input  logic             negate,
  output logic [Width-1:0] result
);

  assign result = negate ? (~value + Width'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (shift-add) and divide (restoring) on operand magnitudes.
// Define MULT_DIV_DZERO_CHECK_EN to short-circuit divide-by-zero with a dzero pulse.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MULT_on,
  input  logic              DIV_on,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] Hi,
  output logic [WORD_W-1:0] Lo,
  output logic              busy,
  output logic              done,
  output logic              dzero
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic              is_mult_q, neg_lo_q, neg_hi_q;

  logic [WORD_W-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WORD_W-1:0] prod_fix;

  sign_fix #(.Width(WORD_W)) u_abs_a (.value(A), .negate(A[WORD_W-1]), .result(abs_a));
  sign_fix #(.Width(WORD_W)) u_abs_b (.value(B), .negate(B[WORD_W-1]), .result(abs_b));

  sign_fix #(.Width(2*WORD_W)) u_fix_prod (
    .value ({acc_hi_q, acc_lo_q}),
    .negate(neg_lo_q),
    .result(prod_fix)
  );
  sign_fix #(.Width(WORD_W)) u_fix_quo (.value(acc_lo_q), .negate(neg_lo_q), .result(quo_fix));
  sign_fix #(.Width(WORD_W)) u_fix_rem (.value(acc_hi_q), .negate(neg_hi_q), .result(rem_fix));

  // acc_hi/acc_lo hold {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [WORD_W:0]   add_sum, rem_shift;
  logic [WORD_W-1:0] rem_diff, step_hi, step_lo;
  logic              rem_ge;

  always_comb begin
    add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {acc_hi_q, acc_lo_q[WORD_W-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_diff  = rem_shift[WORD_W-1:0] - opnd_q;
    if (is_mult_q) begin
      step_hi = add_sum[WORD_W:1];
      step_lo = {add_sum[0], acc_lo_q[WORD_W-1:1]};
    end else begin
      step_hi = rem_ge ? rem_diff : rem_shift[WORD_W-1:0];
      step_lo = {acc_lo_q[WORD_W-2:0], rem_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_mult_q <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dzero     <= 1'b0;
    end else begin
      done  <= 1'b0;
      dzero <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (MULT_on) begin
            state_q   <= StMult;
            busy      <= 1'b1;
            is_mult_q <= 1'b1;
            acc_hi_q  <= '0;
            acc_lo_q  <= abs_b;
            opnd_q    <= abs_a;
            neg_lo_q  <= A[WORD_W-1] ^ B[WORD_W-1];
            neg_hi_q  <= A[WORD_W-1] ^ B[WORD_W-1];
          end else if (DIV_on) begin
`ifdef MULT_DIV_DZERO_CHECK_EN
            if (B == '0) begin
              state_q <= StDone;
              busy    <= 1'b1;
              done    <= 1'b1;
              dzero   <= 1'b1;
            end else
`endif
            begin
              state_q   <= StDiv;
              busy      <= 1'b1;
              is_mult_q <= 1'b0;
              acc_hi_q  <= '0;
              acc_lo_q  <= abs_a;
              opnd_q    <= abs_b;
              neg_lo_q  <= A[WORD_W-1] ^ B[WORD_W-1];
              neg_hi_q  <= A[WORD_W-1];
            end
          end
        end
        StMult, StDiv: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_q <= StFix;
        end
        StFix: begin
          if (is_mult_q) begin
            Hi <= prod_fix[2*WORD_W-1:WORD_W];
            Lo <= prod_fix[WORD_W-1:0];
          end else begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model, per-cycle compare, directed
// corner cases. Honours MULT_DIV_DZERO_CHECK_EN when defined.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, MULT_on, DIV_on;
  logic [31:0] A, B, Hi, Lo;
  logic        busy, done, dzero;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

`ifdef MULT_DIV_DZERO_CHECK_EN
  localparam bit DzeroEn = 1'b1;
`else
  localparam bit DzeroEn = 1'b0;
`endif

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .MULT_on(MULT_on),
    .DIV_on (DIV_on),
    .A      (A),
    .B      (B),
    .Hi     (Hi),
    .Lo     (Lo),
    .busy   (busy),
    .done   (done),
    .dzero  (dzero)
  );

  always #5 clk = ~clk;

  // Reference result {Hi, Lo} from plain signed arithmetic.
  function automatic logic [63:0] ref_result(input logic is_mult, input logic [31:0] a, b);
    longint sa, sb, q, r, p;
    sa = $signed(a);
    sb = $signed(b);
    if (is_mult) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'h0) begin
      q = a[31] ? -longint'(32'hFFFF_FFFF) : longint'(32'hFFFF_FFFF);
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle model: an accepted start shows done 33 edges later, busy drops one edge after that.
  logic        m_busy, m_done, m_dzero;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk) begin
    m_done  <= 1'b0;
    m_dzero <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (!m_busy) begin
      if (MULT_on || DIV_on) begin
        m_busy <= 1'b1;
        if (!MULT_on && B == 32'h0 && DzeroEn) begin
          m_done  <= 1'b1;
          m_dzero <= 1'b1;
          m_left  <= 0;
        end else begin
          m_left <= 33;
          m_res  <= ref_result(MULT_on, A, B);
        end
      end
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left <= 0;
      m_done <= 1'b1;
      m_hi   <= m_res[63:32];
      m_lo   <= m_res[31:0];
    end else begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if ({busy, done, dzero, Hi, Lo} === {m_busy, m_done, m_dzero, m_hi, m_lo}) n_pass++;
      else $display("FAIL cycle_compare t=%0t dut busy=%b done=%b dzero=%b Hi=%h Lo=%h ; model busy=%b done=%b dzero=%b Hi=%h Lo=%h",
                    $time, busy, done, dzero, Hi, Lo, m_busy, m_done, m_dzero, m_hi, m_lo);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MULT_on = m;
    DIV_on  = d;
    A       = a;
    B       = b;
    @(negedge clk);
    MULT_on = 1'b0;
    DIV_on  = 1'b0;
    A       = $urandom;
    B       = $urandom;
  endtask

  // Counts negedges after the start edge until done is seen; bounded at 40.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    start_op(m, d, a, b);
    wait_done(lat);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_hi"}, 64'(Hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(Lo), 64'(exp_lo));
    check({name, "_dzero"}, 64'(dzero), 64'(exp_lat == 0));
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  lat;
    bit  saw_done;
    int  r;
    reset   = 1'b1;
    MULT_on = 1'b0;
    DIV_on  = 1'b0;
    A       = '0;
    B       = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    check("reset_hi", 64'(Hi), 64'h0);
    check("reset_lo", 64'(Lo), 64'h0);
    check("reset_flags", 64'({busy, done, dzero}), 64'h0);

    run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
`ifdef MULT_DIV_DZERO_CHECK_EN
    run_op("div_9_0", 1'b0, 1'b1, 32'd9, 32'h0, 32'h4000_0000, 32'h0, 0);
`else
    run_op("div_9_0", 1'b0, 1'b1, 32'd9, 32'h0, 32'd9, 32'hFFFF_FFFF, 33);
`endif
    run_op("both_on", 1'b1, 1'b1, 32'd6, 32'd3, 32'h0, 32'd18, 33);
    run_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33);

    // Second start while busy must not disturb the first operation.
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    MULT_on = 1'b1;
    A       = 32'd100;
    B       = 32'd100;
    @(negedge clk);
    MULT_on = 1'b0;
    wait_done(lat);
    check("busy_restart_latency", 64'(lat), 64'd27);
    check("busy_restart_lo", 64'(Lo), 64'd15);
    check("busy_restart_hi", 64'(Hi), 64'd0);
    @(negedge clk);

    // Start presented during the done cycle is dropped.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done(lat);
    MULT_on = 1'b1;
    A       = 32'd5;
    B       = 32'd5;
    @(negedge clk);
    MULT_on = 1'b0;
    check("done_cycle_start_busy", 64'(busy), 64'd0);
    check("done_cycle_start_lo", 64'(Lo), 64'd14);
    check("done_cycle_start_hi", 64'(Hi), 64'd2);
    @(negedge clk);
    check("done_cycle_start_still_idle", 64'(busy), 64'd0);

    // Reset sampled at the tenth edge after the start aborts the multiply.
    start_op(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);

    // Random traffic, checked every cycle against the model.
    repeat (6000) begin
      @(negedge clk);
      r       = int'($urandom % 100);
      MULT_on = (r < 6);
      DIV_on  = (r >= 4 && r < 11);
      A       = pick();
      B       = pick();
      reset   = ($urandom % 1500 == 0);
    end
    @(negedge clk);
    MULT_on = 1'b0;
    DIV_on  = 1'b0;
    reset   = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port MULT_on, input, 1 bit: start signed multiply, sampled in IDLE only.
REQ-004 SHALL have port DIV_on, input, 1 bit: start signed divide, sampled in IDLE only.
REQ-005 SHALL have port A, input, 32 bits: multiplicand or dividend, latched on the accepted start edge.
REQ-006 SHALL have port B, input, 32 bits: multiplier or divisor, latched on the accepted start edge.
REQ-007 SHALL have port Hi, output, 32 bits: product[63:32] or remainder.
REQ-008 SHALL have port Lo, output, 32 bits: product[31:0] or quotient.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start through the DONE cycle.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; Hi/Lo are valid from this cycle onward.
REQ-011 SHALL have port dzero, output, 1 bit: one-cycle pulse signalling divide-by-zero.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, FIX, DONE.
REQ-013 In IDLE, MULT_on=1 SHALL latch A/B and go to MULT; DIV_on=1 (MULT_on=0) SHALL latch A/B and go to DIV.
REQ-014 If MULT_on and DIV_on are both 1 in IDLE, the multiply SHALL win.
REQ-015 MULT and DIV SHALL each take exactly 32 cycles, counted by a 5-bit counter 0..31.
REQ-016 Each iteration SHALL be one shift-add step (multiply) or one restoring step (divide) on operand magnitudes.
REQ-017 At counter 31 the FSM SHALL go to FIX, apply sign correction for 1 cycle, then go to DONE.
REQ-018 Signed multiply SHALL produce the full 64-bit two's-complement product.
REQ-019 Divide quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-020 0x80000000 / 0xFFFFFFFF SHALL yield Lo=0x80000000, Hi=0 (wrap, no flag).
REQ-021 Hi/Lo SHALL update only on entry to DONE and hold their value otherwise; done=1 in DONE, then IDLE next cycle.
REQ-022 Latency SHALL be 34 cycles: start accepted at edge N gives done=1 during cycle N+34.
REQ-023 MULT_on/DIV_on asserted outside IDLE SHALL be ignored; the latched operands SHALL not change.
REQ-024 A start in the DONE cycle SHALL be ignored; back-to-back operations need one IDLE cycle.

Reset
REQ-025 reset=1 SHALL force IDLE, counter=0, Hi=0, Lo=0, busy=0, done=0, dzero=0 on the next edge.
REQ-026 reset SHALL take priority over all other inputs.
REQ-027 reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-028 With macro MULT_DIV_DZERO_CHECK_EN defined, DIV_on with B=0 SHALL go IDLE->DONE in one cycle: dzero=1 and done=1 together, Hi/Lo unchanged.
REQ-029 Without MULT_DIV_DZERO_CHECK_EN, dzero SHALL be tied 0 and B=0 SHALL run the full divide.
REQ-030 In that full divide, the magnitude quotient SHALL be 0xFFFFFFFF and the remainder |A|, then sign-corrected per REQ-019.

Structure
REQ-031 Package mult_div_pkg SHALL hold: the state encoding, WORD_W=32, ITER=32 and the counter width.
REQ-032 The datapath SHALL be inline, except one natural sub-module sign_fix (conditional two's-complement negate, 32/64-bit).

Verification
REQ-033 MULT_on with A=7, B=0xFFFFFFFD -> done at N+34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-034 DIV_on with A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-035 DIV_on with A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
REQ-036 DIV_on with A=9, B=0: with macro, dzero=done=1 at N+1 and Hi/Lo unchanged; without, done at N+34 with Lo=0xFFFFFFFF, Hi=9.
REQ-037 reset at cycle N+10 of a multiply -> next cycle busy=0, Hi=Lo=0, no done.
REQ-038 A second MULT_on while busy -> ignored, and the first result is unaffected.
